incr_decr_pattern_gen: RTL
==========================

INCR_DECR_PATTERN_GEN -- requirements
Module: incr_decr_pattern_gen

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-004 SHALL have port mode  input  2  pattern: 00 INCR, 01 DECR, 10 HOLD, 11 JUMP.
REQ-005 SHALL have port seed  input  4  first sample value of burst.
REQ-006 SHALL have port count  input  4  burst length in samples; 0 means 16.
REQ-007 SHALL have port jump  input  4  JUMP step magnitude; 0 or 1 treated as 2.
REQ-008 SHALL have port data  output  4  generated sample stream.
REQ-009 SHALL have port valid  output  1  data carries a burst sample this cycle.
REQ-010 SHALL have port busy  output  1  burst in progress (RUN or DONE state).
REQ-011 SHALL have port done  output  1  one-cycle pulse after last sample.
REQ-012 SHALL have ports exp_incr, exp_decr, exp_error  output  1 each  expected series-detector flags.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 SHALL latch mode, seed, count, jump and go to RUN next edge; start=0 stays IDLE.
REQ-015 First RUN cycle SHALL drive data=seed, valid=1 (latency start->first sample: 1 cycle).
REQ-016 Each later RUN cycle SHALL update data: INCR +1, DECR -1, HOLD unchanged, JUMP +jump_eff; all modulo 16 (15+1=0, 0-1=15).
REQ-017 RUN SHALL emit exactly count samples (16 if count=0) on consecutive cycles, then go to DONE.
REQ-018 DONE SHALL last one cycle with done=1, valid=0, busy=1, then return to IDLE.
REQ-019 start, mode, seed, count, jump SHALL be ignored outside IDLE; latched values are fixed for the burst.
REQ-020 When valid=0, data SHALL hold its last value.
REQ-021 Internal register prev SHALL capture data on every clock edge, regardless of valid.
REQ-022 Each clock, exp_* SHALL register a comparison of data vs prev using unwrapped 4-bit unsigned values: data=prev+1 -> exp_incr; data=prev-1 -> exp_decr; |data-prev|>1 -> exp_error; data=prev -> all 0.
REQ-023 Exactly zero or one of exp_incr, exp_decr, exp_error SHALL be high in any cycle.
REQ-024 Wrap transitions (15->0, 0->15) SHALL produce exp_error, not exp_incr/exp_decr.
REQ-025 exp_* SHALL lag the compared sample by one cycle, aligned with a detector clocked on the same data.

Reset
REQ-026 reset=1 SHALL force state IDLE, data=0, prev=0, valid=0, busy=0, done=0, exp_*=0 at next edge.
REQ-027 reset SHALL take priority over start and abort a burst mid-RUN or in DONE without a done pulse.
REQ-028 First cycle after reset release SHALL accept start normally.

Configuration
REQ-029 Macro INCR_DECR_PATTERN_GEN_EXPECT_EN defined: prev register and exp_* logic SHALL be compiled in per REQ-021..025.
REQ-030 Macro undefined: exp_incr, exp_decr, exp_error SHALL be constant 0; prev logic SHALL be omitted; all other behaviour unchanged.

Verification
REQ-031 reset, start, mode=00, seed=13, count=5 -> data 13,14,15,0,1 with valid=1 for 5 cycles, then done pulse; exp_* (EXPECT_EN) = error (0->13), incr, incr, error, incr.
REQ-032 mode=01, seed=2, count=4 -> data 2,1,0,15; exp after first sample: decr, decr, error.
REQ-033 mode=11, seed=1, jump=0, count=3 -> data 1,3,5 (jump_eff=2); exp_error each sample; mode=10 seed=7 count=3 -> 7,7,7, exp all 0 after first.
REQ-034 count=0, mode=00, seed=0 -> 16 samples 0..15, done after 16th; start pulsed during RUN ignored, no re-trigger.
REQ-035 reset asserted on 3rd RUN cycle -> next edge data=0, valid=0, busy=0, done never pulses; start next cycle begins new burst.
REQ-036 Build without EXPECT_EN, repeat REQ-031 -> identical data/valid/busy/done, exp_* always 0.

Source files
------------

// File: rtl/incr_decr_pattern_gen.sv
// Burst pattern generator (INCR/DECR/HOLD/JUMP) with an optional series-detector reference.
// Define INCR_DECR_PATTERN_GEN_EXPECT_EN to build the prev register and exp_* flags.
module incr_decr_pattern_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [3:0] seed,
    input  logic [3:0] count,
    input  logic [3:0] jump,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       exp_incr,
    output logic       exp_decr,
    output logic       exp_error
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic [1:0] ModeIncr = 2'b00;
    localparam logic [1:0] ModeDecr = 2'b01;
    localparam logic [1:0] ModeHold = 2'b10;
    localparam logic [1:0] ModeJump = 2'b11;

    state_t     r_state;
    logic [1:0] r_mode;
    logic [3:0] r_jump_eff;
    logic [3:0] r_left;

    state_t     w_state_nxt;
    logic [1:0] w_mode_nxt;
    logic [3:0] w_jump_nxt;
    logic [3:0] w_left_nxt;
    logic [3:0] w_data_nxt;
    logic       w_valid_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic [3:0] w_step;
    logic [3:0] w_data_adv;

    always_comb begin
        w_step = 4'd0;
        case (r_mode)
            ModeIncr: w_step = 4'd1;
            ModeDecr: w_step = 4'hF;
            ModeHold: w_step = 4'd0;
            ModeJump: w_step = r_jump_eff;
            default:  w_step = 4'd0;
        endcase
    end

    assign w_data_adv = data + w_step;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_jump_nxt  = r_jump_eff;
        w_left_nxt  = r_left;
        w_data_nxt  = data;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StRun;
                    w_mode_nxt  = mode;
                    w_jump_nxt  = (jump < 4'd2) ? 4'd2 : jump;
                    // Samples still owed after the seed; count=0 wraps to 15, i.e. 16 in total.
                    w_left_nxt  = count - 4'd1;
                    w_data_nxt  = seed;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            StRun: begin
                w_busy_nxt = 1'b1;
                if (r_left == 4'd0) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_data_nxt  = w_data_adv;
                    w_valid_nxt = 1'b1;
                    w_left_nxt  = r_left - 4'd1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_mode     <= ModeIncr;
            r_jump_eff <= 4'd2;
            r_left     <= 4'd0;
            data       <= 4'd0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_jump_eff <= w_jump_nxt;
            r_left     <= w_left_nxt;
            data       <= w_data_nxt;
            valid      <= w_valid_nxt;
            busy       <= w_busy_nxt;
            done       <= w_done_nxt;
        end
    end

`ifdef INCR_DECR_PATTERN_GEN_EXPECT_EN
    logic [3:0] r_prev;
    logic       w_up;
    logic       w_dn;
    logic       w_eq;

    // Unwrapped compare: 15->0 and 0->15 fall through to the error flag.
    assign w_up = ({1'b0, data} == ({1'b0, r_prev} + 5'd1));
    assign w_dn = (({1'b0, data} + 5'd1) == {1'b0, r_prev});
    assign w_eq = (data == r_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= 4'd0;
            exp_incr  <= 1'b0;
            exp_decr  <= 1'b0;
            exp_error <= 1'b0;
        end else begin
            r_prev    <= data;
            exp_incr  <= w_up;
            exp_decr  <= w_dn;
            exp_error <= ~(w_up | w_dn | w_eq);
        end
    end
`else
    assign exp_incr  = 1'b0;
    assign exp_decr  = 1'b0;
    assign exp_error = 1'b0;
`endif

endmodule
